// File: rtl/sensor_spi_arbiter.sv
// rtl/sensor_spi_arbiter.sv - round-robin transaction arbiter sharing one SPI engine between two sensor controllers
module sensor_spi_arbiter #(
  parameter int CS_SETUP_CYCLES = 4,
  parameter int GUARD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] tx_valid,
  input  logic [7:0] tx_byte0,
  input  logic [7:0] tx_byte1,
  input  logic [1:0] tx_last,
  output logic [1:0] tx_ready,
  output logic [1:0] gnt,
  output logic [1:0] rx_valid,
  output logic [7:0] rx_byte,
  output logic [1:0] cs_n,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic [1:0] timeout
);

  localparam int SW = $clog2(CS_SETUP_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, BUSY, RELEASE} state_t;

  state_t        state, state_nx;
  logic          owner;        // requester holding the grant
  logic          last_served;  // round-robin pointer: loser of the next tie
  logic          last_flag;    // byte in flight ends the transaction
  logic [SW-1:0] setup_cnt;
  logic [GW-1:0] guard_cnt;
  logic [TW-1:0] idle_cnt;

  logic          win;
  logic          accept;
  logic          take_rx;
  logic          fire_timeout;
  logic [1:0]    owner_oh;
  logic          req_own;
  logic          tx_valid_own;
  logic          tx_last_own;
  logic [7:0]    tx_byte_own;

  assign owner_oh     = owner ? 2'b10 : 2'b01;
  assign req_own      = req[owner];
  assign tx_valid_own = tx_valid[owner];
  assign tx_last_own  = tx_last[owner];
  assign tx_byte_own  = owner ? tx_byte1 : tx_byte0;

  // Grant, chip selects and byte handshake follow directly from the state
  assign gnt      = (state == SETUP || state == XFER || state == BUSY) ? owner_oh : 2'b00;
  assign cs_n     = ~gnt;
  assign tx_ready = (state == XFER) ? owner_oh : 2'b00;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic, arbitration winner and single-cycle strobes
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    take_rx      = 1'b0;
    fire_timeout = 1'b0;
    win          = ~last_served;
    if (req == 2'b01)      win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
    case (state)
      IDLE:    if (req != 2'b00) state_nx = SETUP;
      SETUP:   if (setup_cnt == SW'(CS_SETUP_CYCLES - 1)) state_nx = XFER;
      XFER: begin
        if (!req_own) begin
          state_nx = RELEASE;
        end else if (tx_valid_own) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          fire_timeout = 1'b1;
          state_nx     = RELEASE;
        end
      end
      BUSY: begin
        if (spi_done) begin
          take_rx  = 1'b1;
          state_nx = (last_flag || !req_own) ? RELEASE : XFER;
        end
      end
      RELEASE: if (guard_cnt == GW'(GUARD_CYCLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers, pulse outputs, round-robin pointer and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      last_flag   <= 1'b0;
      spi_tx      <= 8'h00;
      spi_start   <= 1'b0;
      rx_byte     <= 8'h00;
      rx_valid    <= 2'b00;
      timeout     <= 2'b00;
      setup_cnt   <= '0;
      guard_cnt   <= '0;
      idle_cnt    <= '0;
    end else begin
      spi_start <= accept;
      rx_valid  <= take_rx ? owner_oh : 2'b00;
      timeout   <= fire_timeout ? owner_oh : 2'b00;

      if (state == IDLE && req != 2'b00) owner <= win;
      if (state == RELEASE) last_served <= owner;

      if (accept) begin
        spi_tx    <= tx_byte_own;
        last_flag <= tx_last_own;
      end
      if (take_rx) rx_byte <= spi_rx;

      if (state == SETUP) begin
        if (setup_cnt < SW'(CS_SETUP_CYCLES - 1)) setup_cnt <= setup_cnt + 1'b1;
      end else begin
        setup_cnt <= '0;
      end

      if (state == RELEASE) begin
        if (guard_cnt < GW'(GUARD_CYCLES - 1)) guard_cnt <= guard_cnt + 1'b1;
      end else begin
        guard_cnt <= '0;
      end

      // Idle time only accumulates in XFER; it survives BUSY and clears on each accepted byte
      if (state == XFER) begin
        if (tx_valid_own)                        idle_cnt <= '0;
        else if (idle_cnt != TW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + 1'b1;
      end else if (state == IDLE || state == RELEASE) begin
        idle_cnt <= '0;
      end
    end
  end

endmodule
